// File: rtl/i2s_apb_if.sv
// APB bus bundle between the CPU-side master and the I2S register front-end.
interface i2s_apb_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/i2s_apb_regs.sv
// APB register front-end for the I2S block: config word packing, TX byte push, RX byte pop,
// sticky error status and level irq. Define I2S_APB_RX_EN to build the optional RX path.
//
// state  | meaning
// IDLE   | waiting for an APB setup cycle
// ACCESS | first access cycle; response already registered unless an RX pop is under way
// RXPOP  | rx_fifo_rdata valid, captured into prdata
// RXWAIT | RX read completes with pready=1
module i2s_apb_regs #(
    parameter int ADDR_WIDTH        = 8,
    parameter int CONFIG_DATA_WIDTH = 40,
    parameter int PHY_FIFO_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    i2s_apb_if.slave                     apb,
    input  logic                         config_fifo_full,
    output logic                         config_fifo_wr_en,
    output logic [CONFIG_DATA_WIDTH-1:0] config_fifo_wdata,
    input  logic                         tx_fifo_full,
    input  logic                         tx_fifo_empty,
    output logic                         tx_fifo_wr_en,
    output logic [PHY_FIFO_WIDTH-1:0]    tx_fifo_wdata,
    input  logic                         rx_fifo_empty,
    output logic                         rx_fifo_rd_en,
    input  logic [PHY_FIFO_WIDTH-1:0]    rx_fifo_rdata,
    output logic                         irq
);

`ifdef I2S_APB_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    localparam int HI_W = CONFIG_DATA_WIDTH - 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RXPOP, RXWAIT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [31:0]        cfg_lo_q, cfg_lo_d;
    logic [HI_W-1:0]    cfg_hi_q, cfg_hi_d;
    // sticky bits: [0] tx_ovf, [1] cfg_ovf, [2] rx_udf
    logic [2:0]         sticky_q, sticky_d, sticky_set, sticky_clr;
    logic [31:0]        prdata_q, prdata_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic               cfg_wr_q, cfg_wr_d;
    logic               tx_wr_q, tx_wr_d;
    logic [PHY_FIFO_WIDTH-1:0] tx_wdata_q, tx_wdata_d;
    logic               rx_rd_q, rx_rd_d;
    logic               irq_q, irq_d;

    logic               setup;
    logic [2:0]         offset;
    logic [31:0]        status;
    logic               unused_paddr;

    assign setup  = apb.psel & ~apb.penable;
    assign offset = apb.paddr[4:2];
    assign status = {25'd0, sticky_q, RX_EN & rx_fifo_empty, config_fifo_full,
                     tx_fifo_empty, tx_fifo_full};
    assign unused_paddr = ^{apb.paddr[ADDR_WIDTH-1:5], apb.paddr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        cfg_lo_d   = cfg_lo_q;
        cfg_hi_d   = cfg_hi_q;
        tx_wdata_d = tx_wdata_q;
        sticky_set = '0;
        sticky_clr = '0;
        prdata_d   = '0;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        cfg_wr_d   = 1'b0;
        tx_wr_d    = 1'b0;
        rx_rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d  = ACCESS;
                    pready_d = 1'b1;
                    case (offset)
                        3'd0: begin
                            if (apb.pwrite) ctrl_d   = apb.pwdata[2:0];
                            else            prdata_d = {29'd0, ctrl_q};
                        end
                        3'd1: begin
                            if (apb.pwrite) sticky_clr = apb.pwdata[6:4];
                            else            prdata_d   = status;
                        end
                        3'd2: begin
                            if (apb.pwrite) cfg_lo_d = apb.pwdata;
                            else            prdata_d = cfg_lo_q;
                        end
                        3'd3: begin
                            if (apb.pwrite) cfg_hi_d = apb.pwdata[HI_W-1:0];
                            else            prdata_d = 32'(cfg_hi_q);
                        end
                        3'd4: begin
                            if (!apb.pwrite) begin
                                pslverr_d = 1'b1;
                            end else if (config_fifo_full) begin
                                pslverr_d     = 1'b1;
                                sticky_set[1] = 1'b1;
                            end else begin
                                cfg_wr_d = 1'b1;
                            end
                        end
                        3'd5: begin
                            if (!apb.pwrite) begin
                                pslverr_d = 1'b1;
                            end else if (tx_fifo_full) begin
                                pslverr_d     = 1'b1;
                                sticky_set[0] = 1'b1;
                            end else begin
                                tx_wr_d    = 1'b1;
                                tx_wdata_d = apb.pwdata[PHY_FIFO_WIDTH-1:0];
                            end
                        end
                        3'd6: begin
                            if (!RX_EN || apb.pwrite) begin
                                pslverr_d = 1'b1;
                            end else if (rx_fifo_empty) begin
                                pslverr_d     = 1'b1;
                                sticky_set[2] = 1'b1;
                            end else begin
                                rx_rd_d  = 1'b1;
                                pready_d = 1'b0;
                            end
                        end
                        default: pslverr_d = 1'b1;
                    endcase
                end
            end
            // the registered rd_en marks a legal RX pop in flight
            ACCESS: state_d = rx_rd_q ? RXPOP : IDLE;
            RXPOP: begin
                state_d  = RXWAIT;
                pready_d = 1'b1;
                prdata_d = 32'(rx_fifo_rdata);
            end
            RXWAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a same-cycle error set beats the W1C clear
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
        irq_d    = (ctrl_q[0] & RX_EN & ~rx_fifo_empty) | (ctrl_q[1] & tx_fifo_empty) |
                   (ctrl_q[2] & (|sticky_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            cfg_lo_q   <= '0;
            cfg_hi_q   <= '0;
            sticky_q   <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            cfg_wr_q   <= 1'b0;
            tx_wr_q    <= 1'b0;
            tx_wdata_q <= '0;
            rx_rd_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            cfg_lo_q   <= cfg_lo_d;
            cfg_hi_q   <= cfg_hi_d;
            sticky_q   <= sticky_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            cfg_wr_q   <= cfg_wr_d;
            tx_wr_q    <= tx_wr_d;
            tx_wdata_q <= tx_wdata_d;
            rx_rd_q    <= rx_rd_d;
            irq_q      <= irq_d;
        end
    end

    assign apb.prdata        = prdata_q;
    assign apb.pready        = pready_q;
    assign apb.pslverr       = pslverr_q;
    assign config_fifo_wr_en = cfg_wr_q;
    assign config_fifo_wdata = {cfg_hi_q, cfg_lo_q};
    assign tx_fifo_wr_en     = tx_wr_q;
    assign tx_fifo_wdata     = tx_wdata_q;
    assign irq               = irq_q;

`ifdef I2S_APB_RX_EN
    assign rx_fifo_rd_en = rx_rd_q;
`else
    assign rx_fifo_rd_en = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_apb_regs.sv
// Directed bench for i2s_apb_regs; covers both builds of the I2S_APB_RX_EN option.
module tb_i2s_apb_regs;
    localparam int AW = 8;
    localparam int CW = 40;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          config_fifo_full = 1'b0;
    logic          config_fifo_wr_en;
    logic [CW-1:0] config_fifo_wdata;
    logic          tx_fifo_full = 1'b0;
    logic          tx_fifo_empty = 1'b0;
    logic          tx_fifo_wr_en;
    logic [PW-1:0] tx_fifo_wdata;
    logic          rx_fifo_empty = 1'b0;
    logic          rx_fifo_rd_en;
    logic [PW-1:0] rx_fifo_rdata = '0;
    logic [PW-1:0] rx_head = 8'h5C;
    logic          irq;

    int checks = 0;
    int errors = 0;
    int n_cfg = 0, n_tx = 0, n_rd = 0, n_bad = 0;
    logic [CW-1:0] last_cfg = '0;
    logic [PW-1:0] last_tx = '0;
    logic          rd_seen = 1'b0;

    i2s_apb_if #(.ADDR_WIDTH(AW)) apb_bus ();

    i2s_apb_regs #(
        .ADDR_WIDTH(AW), .CONFIG_DATA_WIDTH(CW), .PHY_FIFO_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .apb(apb_bus),
        .config_fifo_full(config_fifo_full), .config_fifo_wr_en(config_fifo_wr_en),
        .config_fifo_wdata(config_fifo_wdata),
        .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wdata(tx_fifo_wdata),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en),
        .rx_fifo_rdata(rx_fifo_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // strobe monitor: every high strobe cycle is one push/pop and must coincide with pready
    always @(negedge clk) begin
        if (config_fifo_wr_en) begin
            n_cfg++;
            last_cfg = config_fifo_wdata;
            if (!apb_bus.pready) n_bad++;
        end
        if (tx_fifo_wr_en) begin
            n_tx++;
            last_tx = tx_fifo_wdata;
            if (!apb_bus.pready) n_bad++;
        end
        if (rx_fifo_rd_en) n_rd++;
        rd_seen = rx_fifo_rd_en;
    end

    // RX FIFO model: data valid only in the cycle after rd_en
    always @(posedge clk) begin
        #1;
        rx_fifo_rdata = rd_seen ? rx_head : '0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rdat, output logic err, output int waits);
        @(posedge clk); #1;
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = wr;
        apb_bus.paddr   = addr;
        apb_bus.pwdata  = wd;
        @(posedge clk); #1;
        apb_bus.penable = 1'b1;
        waits = 0;
        while (!apb_bus.pready && waits < 10) begin
            @(posedge clk); #1;
            waits++;
        end
        chk("pready_seen", apb_bus.pready, 1'b1);
        rdat = apb_bus.prdata;
        err  = apb_bus.pslverr;
        @(posedge clk); #1;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        chk("rsp_clear", {apb_bus.pready, apb_bus.pslverr, apb_bus.prdata}, '0);
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic exp_err);
        logic [31:0] rdat;
        logic        err;
        int          w;
        apb_xfer(a, 1'b1, d, rdat, err, w);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_wait"}, w, 0);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp_d,
                      input logic exp_err, input int exp_w);
        logic [31:0] rdat;
        logic        err;
        int          w;
        apb_xfer(a, 1'b0, 32'h0, rdat, err, w);
        chk({tag, "_data"}, rdat, exp_d);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_wait"}, w, exp_w);
    endtask

    initial begin
        int rd_before;
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
        apb_bus.paddr   = '0;
        apb_bus.pwdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_apb", {apb_bus.pready, apb_bus.pslverr, apb_bus.prdata}, '0);
        chk("rst_strb", {irq, config_fifo_wr_en, tx_fifo_wr_en, rx_fifo_rd_en, tx_fifo_wdata}, '0);
        chk("rst_cfgw", config_fifo_wdata, '0);
        rst = 1'b0;

        wr("ctrl_w", 8'h00, 32'hFFFF_FFFF, 1'b0);
        rd("ctrl_r", 8'h00, 32'h7, 1'b0, 0);
        wr("ctrl_w0", 8'h00, 32'h0, 1'b0);

        wr("cfglo_w", 8'h08, 32'hDEAD_BEEF, 1'b0);
        wr("cfghi_w", 8'h0C, 32'h0000_00A5, 1'b0);
        rd("cfglo_r", 8'h08, 32'hDEAD_BEEF, 1'b0, 0);
        rd("cfghi_r", 8'h0C, 32'h0000_00A5, 1'b0, 0);
        wr("commit1", 8'h10, 32'h0, 1'b0);
        chk("commit1_cnt", n_cfg, 1);
        chk("commit1_data", last_cfg, 40'hA5_DEAD_BEEF);
        wr("commit2", 8'h10, 32'h1234, 1'b0);
        chk("commit2_cnt", n_cfg, 2);
        chk("commit2_data", last_cfg, 40'hA5_DEAD_BEEF);
        wr("cfghi_wide", 8'h0C, 32'hFFFF_FF5A, 1'b0);
        rd("cfghi_mask", 8'h0C, 32'h0000_005A, 1'b0, 0);

        tx_fifo_full = 1'b1;
        wr("tx_ovf", 8'h14, 32'h1234, 1'b1);
        chk("tx_ovf_cnt", n_tx, 0);
        rd("stat_txovf", 8'h04, 32'h11, 1'b0, 0);
        wr("stat_w1c_other", 8'h04, 32'h60, 1'b0);
        rd("stat_keep", 8'h04, 32'h11, 1'b0, 0);
        wr("stat_w1c", 8'h04, 32'h10, 1'b0);
        rd("stat_clr", 8'h04, 32'h01, 1'b0, 0);
        tx_fifo_full = 1'b0;

        wr("tx_ok", 8'h14, 32'h1234, 1'b0);
        chk("tx_ok_cnt", n_tx, 1);
        chk("tx_ok_data", last_tx, 8'h34);

        config_fifo_full = 1'b1;
        wr("cfg_ovf", 8'h10, 32'h0, 1'b1);
        chk("cfg_ovf_cnt", n_cfg, 2);
        rd("stat_cfgovf", 8'h04, 32'h24, 1'b0, 0);
        config_fifo_full = 1'b0;
        wr("stat_w1c_cfg", 8'h04, 32'h20, 1'b0);
        rd("stat_zero", 8'h04, 32'h00, 1'b0, 0);

        rd("undec_r", 8'h1C, 32'h0, 1'b1, 0);
        wr("undec_w", 8'h1C, 32'h55, 1'b1);
        rd("commit_r", 8'h10, 32'h0, 1'b1, 0);
        rd("txdata_r", 8'h14, 32'h0, 1'b1, 0);
        wr("rxdata_w", 8'h18, 32'h77, 1'b1);
        chk("err_no_push", {n_cfg, n_tx}, {32'd2, 32'd1});

        wr("ctrl_ietx", 8'h00, 32'h2, 1'b0);
        tx_fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("irq_tx", irq, 1'b1);
        tx_fifo_empty = 1'b0;
        wr("ctrl_ieerr", 8'h00, 32'h4, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("irq_quiet", irq, 1'b0);
        tx_fifo_full = 1'b1;
        wr("tx_ovf2", 8'h14, 32'hAB, 1'b1);
        chk("irq_err", irq, 1'b1);
        tx_fifo_full = 1'b0;
        wr("stat_w1c_all", 8'h04, 32'h70, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("irq_err_clr", irq, 1'b0);

        wr("ctrl_ierx", 8'h00, 32'h1, 1'b0);
        repeat (2) @(posedge clk);
`ifdef I2S_APB_RX_EN
        #1 chk("irq_rx", irq, 1'b1);
        wr("ctrl_ieerr2", 8'h00, 32'h4, 1'b0);
        rd("rx_pop", 8'h18, 32'h0000_005C, 1'b0, 2);
        chk("rx_pop_cnt", n_rd, 1);
        rx_fifo_empty = 1'b1;
        rd("rx_udf", 8'h18, 32'h0, 1'b1, 0);
        chk("rx_udf_cnt", n_rd, 1);
        chk("irq_udf", irq, 1'b1);
        rd("stat_udf", 8'h04, 32'h48, 1'b0, 0);
        rx_fifo_empty = 1'b0;
`else
        #1 chk("irq_rx_off", irq, 1'b0);
        rd("rx_off", 8'h18, 32'h0, 1'b1, 0);
        chk("rx_off_cnt", n_rd, 0);
        rx_fifo_empty = 1'b1;
        rd("stat_rx_off", 8'h04, 32'h00, 1'b0, 0);
        rx_fifo_empty = 1'b0;
`endif

        // reset in access cycle 1 aborts the transfer
        rd_before = n_rd;
        @(posedge clk); #1;
        apb_bus.psel    = 1'b1;
        apb_bus.penable = 1'b0;
        apb_bus.pwrite  = 1'b0;
`ifdef I2S_APB_RX_EN
        apb_bus.paddr   = 8'h18;
        @(posedge clk); #1;
        apb_bus.penable = 1'b1;
        chk("abort_pre", rx_fifo_rd_en, 1'b1);
`else
        apb_bus.paddr   = 8'h04;
        @(posedge clk); #1;
        apb_bus.penable = 1'b1;
        chk("abort_pre", apb_bus.pready, 1'b1);
`endif
        rst = 1'b1;
        #1;
        chk("abort_apb", {apb_bus.pready, apb_bus.pslverr, apb_bus.prdata}, '0);
        chk("abort_strb", {irq, config_fifo_wr_en, tx_fifo_wr_en, rx_fifo_rd_en}, '0);
        apb_bus.psel    = 1'b0;
        apb_bus.penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_no_pop", n_rd, rd_before);
        rd("post_rst_stat", 8'h04, 32'h00, 1'b0, 0);
        rd("post_rst_ctrl", 8'h00, 32'h0, 1'b0, 0);
        chk("strobe_align", n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_apb_regs.md
# i2s_apb_regs

APB slave register front-end for the I2S peripheral, upstream of the I2S physical layer. Packs APB writes into full-width configuration words and pushes them into the config FIFO, pushes transmit audio bytes into the transmit PHY FIFO, and pops received bytes from the receive FIFO on APB reads. It also maintains sticky error status and a level interrupt. All three FIFOs are external; this block drives only their write or read sides.

## Interface
- ADDR_WIDTH, 8, APB address width; only PADDR[4:2] is decoded.
- CONFIG_DATA_WIDTH, 40, config word width; legal range 33..64.
- PHY_FIFO_WIDTH, 8, audio byte width for TX and RX.
- clk  in  1  single clock, also the FIFO write/read clock on this side.
- rst  in  1  asynchronous, active-high reset.
- psel, penable, pwrite  in  1  APB control.
- paddr  in  ADDR_WIDTH  APB address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data; registered.
- pready, pslverr  out  1  APB response; registered.
- config_fifo_full  in  1; config_fifo_wr_en  out  1; config_fifo_wdata  out  CONFIG_DATA_WIDTH.
- tx_fifo_full, tx_fifo_empty  in  1; tx_fifo_wr_en  out  1; tx_fifo_wdata  out  PHY_FIFO_WIDTH.
- rx_fifo_empty  in  1; rx_fifo_rd_en  out  1; rx_fifo_rdata  in  PHY_FIFO_WIDTH (valid the cycle after rd_en).
- irq  out  1  level interrupt.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL RW: [0] ie_rx, [1] ie_tx, [2] ie_err.
  - 0x04 STATUS: RO [0] tx_full, [1] tx_empty, [2] cfg_full, [3] rx_empty. Sticky W1C [4] tx_ovf, [5] cfg_ovf, [6] rx_udf.
  - 0x08 CFG_LO RW: config bits [31:0].
  - 0x0C CFG_HI RW: config bits [CONFIG_DATA_WIDTH-1:32]; unused upper bits read 0.
  - 0x10 CFG_COMMIT WO: any write pushes {CFG_HI,CFG_LO}.
  - 0x14 TXDATA WO: pushes pwdata[PHY_FIFO_WIDTH-1:0].
  - 0x18 RXDATA RO: pops one byte, zero-extended.
- FSM states: IDLE, ACCESS, RXPOP, RXWAIT.
  - IDLE → ACCESS on the setup cycle (psel=1, penable=0).
  - ACCESS → IDLE for all accesses except a legal RXDATA read.
  - Legal RXDATA read: ACCESS → RXPOP → RXWAIT → IDLE.
- Errors (pslverr=1, no FIFO/register side effect, prdata=0):
  - CFG_COMMIT with config_fifo_full=1 sets cfg_ovf.
  - TXDATA with tx_fifo_full=1 sets tx_ovf.
  - RXDATA with rx_fifo_empty=1 sets rx_udf.
  - Undecoded offset, write to a RO register, or read of a WO register.
- Full/empty flags are sampled in the setup cycle.
- Sticky set and W1C in the same cycle: set wins.
- CFG_LO/CFG_HI are unchanged by a commit, so the same word can be re-pushed.
- irq = (ie_rx & !rx_empty) | (ie_tx & tx_empty) | (ie_err & (tx_ovf|cfg_ovf|rx_udf)), registered.

## Timing
- Reset values: all outputs 0, all registers 0, FSM in IDLE.
- Reset asserted mid-transfer aborts it; no partial push or pop occurs.
- Writes and non-RXDATA reads have zero wait states.
  - pready=1 in the first access cycle, registered from the setup cycle.
- config_fifo_wr_en and tx_fifo_wr_en are single-cycle pulses coincident with that pready cycle.
  - Write data is valid with the strobe.
- Legal RXDATA read takes 2 wait states:
  - Access cycle 1: rx_fifo_rd_en=1, pready=0.
  - Access cycle 2: rx_fifo_rdata captured into prdata, pready=0.
  - Access cycle 3: pready=1.
- At most one FIFO strobe is asserted per transfer; strobes are never held high.
- pready, pslverr and prdata return to 0 the cycle after completion.
- Back-to-back transfers are supported: a new setup cycle can directly follow a completed access.

## Configuration
- I2S_APB_RX_EN defined:
  - RX path present; RXDATA, rx_empty, rx_udf and ie_rx behave as specified.
- I2S_APB_RX_EN undefined:
  - rx_fifo_rd_en is tied 0.
  - RXDATA decodes as an undecoded offset (pslverr=1).
  - STATUS[3] and STATUS[6] read 0; ie_rx has no effect on irq.

## Test plan
- Write CFG_LO=0xDEADBEEF, CFG_HI=0xA5, CFG_COMMIT, with config FIFO not full → one config_fifo_wr_en pulse with wdata=0xA5DEADBEEF, pslverr=0, zero wait states.
- TXDATA write 0x1234 with tx_fifo_full=1 → no tx_fifo_wr_en, pslverr=1, STATUS reads 0x11. Then write STATUS=0x10 → STATUS reads 0x01.
- RX FIFO holding 0x5C, read RXDATA → rx_fifo_rd_en high for exactly one cycle, pready on access cycle 3, prdata=0x0000005C.
- RXDATA read with rx_fifo_empty=1 → pslverr=1, prdata=0, rx_udf=1. With ie_err=1, irq=1 one cycle after the status update.
- Assert rst during access cycle 1 of an RXDATA read → all outputs 0 asynchronously, FSM in IDLE, no further rd_en. A following STATUS read succeeds.
- Same-cycle conflict: a TXDATA overflow while a W1C of tx_ovf is being written → tx_ovf remains 1.
